// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path:
// FSM state type, opcodes, and the mux/extender select encodings.
package riscv_pkg;

  // Controller sequencing states
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } statetype;

  // Supported opcodes (instr[6:0])
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Immediate extender selects
  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_J  = 3'b011;
  localparam logic [2:0] IMM_U  = 3'b100;
  localparam logic [2:0] IMM_IZ = 3'b101;

  // ALU A operand selects
  localparam logic [1:0] ALUA_PC    = 2'b00;
  localparam logic [1:0] ALUA_OLDPC = 2'b01;
  localparam logic [1:0] ALUA_RS1   = 2'b10;
  localparam logic [1:0] ALUA_ZERO  = 2'b11;

  // ALU B operand selects
  localparam logic [1:0] ALUB_RS2  = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_FOUR = 2'b10;

  // Result mux selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU decoder classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // True for every opcode the multicycle core can execute
  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW)     || (op == OP_SW)   || (op == OP_RTYPE) ||
           (op == OP_IALU)   || (op == OP_BRANCH) ||
           (op == OP_JAL)    || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle datapath and its controller.
// The controller (slave) reads instruction fields and the zero flag and
// drives every select / enable back to the datapath (master).
interface mc_controller_if;
  import riscv_pkg::*;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;

  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [2:0] immsrc;
  logic       illegal;

  modport slave (
    input  op, funct3, zero,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, aluop, immsrc, illegal
  );

  modport master (
    output op, funct3, zero,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, aluop, immsrc, illegal
  );
endinterface

// File: rtl/mc_controller_instrdec.sv
// Opcode to immediate-format decoder. Purely combinational; the
// extender select follows the opcode in every controller state.
module instrdec
  import riscv_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [2:0] immsrc_o
);

  // Map opcode to extender format; unknown opcodes fall back to I-type
  always_comb begin
    immsrc_o = IMM_I;
    case (op_i)
      OP_LW, OP_IALU: immsrc_o = IMM_I;
      OP_SW:          immsrc_o = IMM_S;
      OP_BRANCH:      immsrc_o = IMM_B;
      OP_JAL:         immsrc_o = IMM_J;
      OP_LUI:         immsrc_o = IMM_U;
      default:        immsrc_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore controller: sequences fetch, decode, execute, memory
// and writeback over the shared datapath. Outputs decode from the state
// register; write enables are forced low while reset is asserted so an
// abandoned instruction cannot commit anything.
module mc_controller
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.slave ctl
);

  statetype state_q;

  logic       pcupdate_s;
  logic       branch_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       memwrite_s;
  logic       adrsrc_s;
  logic [1:0] resultsrc_s;
  logic [1:0] alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] aluop_s;
  logic       take_branch;

  // Only funct3[0] matters (beq vs bne); the rest is deliberately ignored
  logic unused_funct3;
  assign unused_funct3 = ^ctl.funct3[2:1];

  instrdec u_instrdec (
    .op_i     (ctl.op),
    .immsrc_o (ctl.immsrc)
  );

  // State register with next-state selection; reset drops straight to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          case (ctl.op)
            OP_LW, OP_SW: state_q <= MEMADR;
            OP_RTYPE:     state_q <= EXECUTER;
            OP_IALU:      state_q <= EXECUTEI;
            OP_BRANCH:    state_q <= BRANCH;
            OP_JAL:       state_q <= JAL;
            OP_LUI:       state_q <= LUI;
            default:      state_q <= FETCH;
          endcase
        end
        MEMADR:   state_q <= (ctl.op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  state_q <= MEMWB;
        EXECUTER: state_q <= ALUWB;
        EXECUTEI: state_q <= ALUWB;
        JAL:      state_q <= ALUWB;
        LUI:      state_q <= ALUWB;
        MEMWB:    state_q <= FETCH;
        MEMWRITE: state_q <= FETCH;
        ALUWB:    state_q <= FETCH;
        BRANCH:   state_q <= FETCH;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Per-state datapath controls; anything not set stays 0
  always_comb begin
    pcupdate_s  = 1'b0;
    branch_s    = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    memwrite_s  = 1'b0;
    adrsrc_s    = 1'b0;
    resultsrc_s = RES_ALUOUT;
    alusrca_s   = ALUA_PC;
    alusrcb_s   = ALUB_RS2;
    aluop_s     = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        irwrite_s   = 1'b1;
        pcupdate_s  = 1'b1;
        alusrca_s   = ALUA_PC;
        alusrcb_s   = ALUB_FOUR;
        resultsrc_s = RES_ALURESULT;
      end
      DECODE: begin
        // OldPC + imm: precomputes the branch/jump target into ALUOut
        alusrca_s = ALUA_OLDPC;
        alusrcb_s = ALUB_IMM;
      end
      MEMADR: begin
        alusrca_s = ALUA_RS1;
        alusrcb_s = ALUB_IMM;
      end
      MEMREAD: adrsrc_s = 1'b1;
      MEMWB: begin
        resultsrc_s = RES_DATA;
        regwrite_s  = 1'b1;
      end
      MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTER: begin
        alusrca_s = ALUA_RS1;
        alusrcb_s = ALUB_RS2;
        aluop_s   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alusrca_s = ALUA_RS1;
        alusrcb_s = ALUB_IMM;
        aluop_s   = ALUOP_FUNCT;
      end
      ALUWB: regwrite_s = 1'b1;
      BRANCH: begin
        alusrca_s = ALUA_RS1;
        alusrcb_s = ALUB_RS2;
        aluop_s   = ALUOP_SUB;
        branch_s  = 1'b1;
      end
      JAL: begin
        // OldPC + 4 becomes the link value while ALUOut (target) loads PC
        alusrca_s  = ALUA_OLDPC;
        alusrcb_s  = ALUB_FOUR;
        pcupdate_s = 1'b1;
      end
      LUI: begin
        alusrca_s = ALUA_ZERO;
        alusrcb_s = ALUB_IMM;
      end
      default: ;
    endcase
  end

  // beq branches on zero, bne on not-zero
  assign take_branch = branch_s & (ctl.zero ^ ctl.funct3[0]);

  assign ctl.pcwrite   = ~reset & (pcupdate_s | take_branch);
  assign ctl.irwrite   = ~reset & irwrite_s;
  assign ctl.regwrite  = ~reset & regwrite_s;
  assign ctl.memwrite  = ~reset & memwrite_s;
  assign ctl.adrsrc    = adrsrc_s;
  assign ctl.resultsrc = resultsrc_s;
  assign ctl.alusrca   = alusrca_s;
  assign ctl.alusrcb   = alusrcb_s;
  assign ctl.aluop     = aluop_s;
  assign ctl.illegal   = (state_q == DECODE) & ~op_supported(ctl.op);

endmodule
